// File: rtl/sr_cmd_seq.sv
// Set/clear command sequencer: synchronizes and debounces two raw requests and
// issues non-overlapping s/r pulses. Optional macro: SR_CMD_SEQ_CONFLICT_CNT_EN.
module sr_cmd_seq #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned PULSE_W  = 2,
  parameter bit          SET_PRIO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_in,
  input  logic       clr_in,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       conflict,
`ifdef SR_CMD_SEQ_CONFLICT_CNT_EN
  output logic [7:0] conflict_cnt,
`endif
  output logic       q_exp
);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_e;

  localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);

  // Bit 0 carries the set channel, bit 1 the clear channel.
  logic [1:0]      raw;
  logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]      deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      pend_q, pend_d, rise, clear;
  state_e          state_q, state_d;
  logic [3:0]      pcnt_q, pcnt_d;
  logic            s_q, s_d, r_q, r_d, conflict_q, conflict_d, q_exp_q, q_exp_d;
  logic            serve_ok;

  assign raw = {clr_in, set_in};

  // State register: every flop clears asynchronously so a pulse in flight is
  // cut off and its request discarded.
  // NOTE: sequential state uses non-blocking assignments only; mixing in
  // blocking writes here would create simulation/synthesis order mismatches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      state_q    <= IDLE;
      pcnt_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      q_exp_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      q_exp_q    <= q_exp_d;
    end
  end

  // Synchronizer and debounce: the level flips only after DEBOUNCE
  // consecutive samples disagree with it.
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  assign rise     = deb_q & ~deb_prev_q;
  assign serve_ok = (state_q == IDLE) || (state_q == GAP);

  // Next-state logic. GAP arbitrates like IDLE, so a request pended during a
  // pulse follows the single gap cycle without an extra idle cycle.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    clear   = '0;
    unique case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        pcnt_d  = '0;
        if (&pend_q) begin
          state_d = SET_PRIO ? PULSE_S : PULSE_R;
          clear   = 2'b11;
        end else if (pend_q[0]) begin
          state_d = PULSE_S;
          clear   = 2'b01;
        end else if (pend_q[1]) begin
          state_d = PULSE_R;
          clear   = 2'b10;
        end
      end
      PULSE_S, PULSE_R: begin
        if (pcnt_q == PULSE_LAST) state_d = GAP;
        else                      pcnt_d  = pcnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    pend_d = (pend_q & ~clear) | rise;
  end

  // Output logic: s/r are decoded from the next state so they register in
  // the same edge as the state, and can never both be high.
  always_comb begin
    s_d        = (state_d == PULSE_S);
    r_d        = (state_d == PULSE_R);
    conflict_d = serve_ok && (&pend_q);
    q_exp_d    = q_exp_q;
    if (state_d == PULSE_S && state_q != PULSE_S) q_exp_d = 1'b1;
    if (state_d == PULSE_R && state_q != PULSE_R) q_exp_d = 1'b0;
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
  assign q_exp    = q_exp_q;
  assign busy     = (state_q != IDLE);

`ifdef SR_CMD_SEQ_CONFLICT_CNT_EN
  logic [7:0] ccnt_q, ccnt_d;

  always_comb begin
    ccnt_d = ccnt_q;
    if (conflict_d && ccnt_q != 8'hFF) ccnt_d = ccnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ccnt_q <= '0;
    else     ccnt_q <= ccnt_d;
  end

  assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_sr_cmd_seq.sv
// Self-checking bench for sr_cmd_seq: a timeline model of the request path
// and pulse server, compared every cycle, plus directed edge-exact checks.
module tb_sr_cmd_seq;

  localparam int DB = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_in = 1'b0;
  logic clr_in = 1'b0;
  logic s0, r0, b0, c0, q0;
  logic s1, r1, b1, c1, q1;
`ifdef SR_CMD_SEQ_CONFLICT_CNT_EN
  logic [7:0] cc0, cc1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sr_cmd_seq #(.DEBOUNCE(DB), .PULSE_W(PW), .SET_PRIO(1'b1)) u_dut_set (
    .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
    .s(s0), .r(r0), .busy(b0), .conflict(c0),
`ifdef SR_CMD_SEQ_CONFLICT_CNT_EN
    .conflict_cnt(cc0),
`endif
    .q_exp(q0)
  );

  sr_cmd_seq #(.DEBOUNCE(DB), .PULSE_W(PW), .SET_PRIO(1'b0)) u_dut_clr (
    .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
    .s(s1), .r(r1), .busy(b1), .conflict(c1),
`ifdef SR_CMD_SEQ_CONFLICT_CNT_EN
    .conflict_cnt(cc1),
`endif
    .q_exp(q1)
  );

  // Model: raw samples reach the debouncer two edges late; a debounced rise
  // becomes pending one edge later; the server owns a fixed window of
  // PW pulse cycles plus one gap cycle and may start a new one in the gap.
  typedef struct packed {
    bit [1:0][1:0] pipe;
    bit [1:0]      lvl;
    bit [1:0][7:0] run;
    bit [1:0]      rose;
    bit [1:0]      pend;
    int            left;
    bit            kind_s;
    bit            q;
    bit            conf;
    int            ccnt;
  } model_t;

  model_t m0, m1;

  function automatic model_t step(input model_t m, input bit si, input bit ci, input bit prio);
    model_t   n = m;
    bit [1:0] raw = {ci, si};
    bit       sample;
    n.conf = 1'b0;
    if (m.left <= 1 && m.pend != 2'b00) begin
      n.conf   = (m.pend == 2'b11);
      n.kind_s = n.conf ? prio : m.pend[0];
      n.q      = n.kind_s;
      n.left   = PW + 1;
      n.pend   = 2'b00;
      if (n.conf && n.ccnt < 255) n.ccnt = n.ccnt + 1;
    end else if (m.left > 0) begin
      n.left = m.left - 1;
    end
    n.pend = n.pend | m.rose;
    for (int ch = 0; ch < 2; ch++) begin
      sample      = m.pipe[ch][1];
      n.pipe[ch]  = {m.pipe[ch][0], raw[ch]};
      n.rose[ch]  = 1'b0;
      if (sample != m.lvl[ch]) begin
        if (int'(m.run[ch]) + 1 >= DB) begin
          n.lvl[ch]  = sample;
          n.run[ch]  = '0;
          n.rose[ch] = sample;
        end else begin
          n.run[ch] = m.run[ch] + 8'd1;
        end
      end else begin
        n.run[ch] = '0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 = '0;
      m1 = '0;
    end else begin
      m0 = step(m0, set_in, clr_in, 1'b1);
      m1 = step(m1, set_in, clr_in, 1'b0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input model_t m, input logic s, input logic r,
                     input logic b, input logic c, input logic q);
    check({tag, ".s"},        32'(s), 32'(m.left >= 2 && m.kind_s));
    check({tag, ".r"},        32'(r), 32'(m.left >= 2 && !m.kind_s));
    check({tag, ".busy"},     32'(b), 32'(m.left > 0));
    check({tag, ".conflict"}, 32'(c), 32'(m.conf));
    check({tag, ".q_exp"},    32'(q), 32'(m.q));
    check({tag, ".s_and_r"},  32'(s & r), 32'd0);
  endtask

  always @(negedge clk) begin
    cmp("dut_set", m0, s0, r0, b0, c0, q0);
    cmp("dut_clr", m1, s1, r1, b1, c1, q1);
  end

  logic [31:0] s0_t, r0_t, b0_t, c0_t, q0_t, s1_t, r1_t, c1_t, q1_t;

  // Runs n edges from the next posedge (edge 0), recording outputs after each
  // edge; clr_in rises before edge clr_edge and set_in drops before edge set_drop.
  task automatic trace(input int n, input int clr_edge, input int set_drop);
    {s0_t, r0_t, b0_t, c0_t, q0_t, s1_t, r1_t, c1_t, q1_t} = '0;
    for (int e = 0; e < n; e++) begin
      @(posedge clk);
      @(negedge clk);
      s0_t[e] = s0; r0_t[e] = r0; b0_t[e] = b0; c0_t[e] = c0; q0_t[e] = q0;
      s1_t[e] = s1; r1_t[e] = r1; c1_t[e] = c1; q1_t[e] = q1;
      if (e + 1 == clr_edge) clr_in = 1'b1;
      if (e + 1 == set_drop) set_in = 1'b0;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    set_in = 1'b0;
    clr_in = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("reset.s", 32'(s0), 32'd0);
    check("reset.busy", 32'(b0), 32'd0);
    check("reset.q_exp", 32'(q0), 32'd0);
    do_reset();

    // Single set request held high
    set_in = 1'b1;
    trace(13, -1, -1);
    check("hold_set.s_edges", s0_t, 32'h0000_0180);
    check("hold_set.busy_edges", b0_t, 32'h0000_0380);
    check("hold_set.q_exp_edges", q0_t, 32'h0000_1F80);
    check("hold_set.r_edges", r0_t, 32'h0);

    // Simultaneous set and clear
    do_reset();
    set_in = 1'b1;
    clr_in = 1'b1;
    trace(14, -1, -1);
    check("both.prio1_s", s0_t, 32'h0000_0180);
    check("both.prio1_r", r0_t, 32'h0);
    check("both.prio1_conflict", c0_t, 32'h0000_0080);
    check("both.prio1_q_exp", q0_t, 32'h0000_3F80);
    check("both.prio0_r", r1_t, 32'h0000_0180);
    check("both.prio0_s", s1_t, 32'h0);
    check("both.prio0_conflict", c1_t, 32'h0000_0080);
    check("both.prio0_q_exp", q1_t, 32'h0);

    // Glitch of three cycles on set_in
    do_reset();
    set_in = 1'b1;
    trace(20, -1, 3);
    check("glitch.s", s0_t | s1_t, 32'h0);
    check("glitch.r", r0_t | r1_t, 32'h0);
    check("glitch.busy", b0_t, 32'h0);
    check("glitch.conflict", c0_t | c1_t, 32'h0);

    // Clear debounced during the set pulse: s, one gap, then r
    do_reset();
    set_in = 1'b1;
    trace(16, 2, -1);
    check("seq.s_edges", s0_t, 32'h0000_0180);
    check("seq.r_edges", r0_t, 32'h0000_0C00);
    check("seq.busy_edges", b0_t, 32'h0000_1F80);
    check("seq.conflict", c0_t, 32'h0);
    check("seq.q_exp_edges", q0_t, 32'h0000_0380);

    // Reset during the second cycle of an s pulse
    do_reset();
    set_in = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("abort.s_before", 32'(s0), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort.s", 32'(s0), 32'd0);
    check("abort.r", 32'(r0), 32'd0);
    check("abort.busy", 32'(b0), 32'd0);
    check("abort.q_exp", 32'(q0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    trace(12, -1, -1);
    check("abort.restart_s_edges", s0_t, 32'h0000_0180);

`ifdef SR_CMD_SEQ_CONFLICT_CNT_EN
    do_reset();
    for (int p = 0; p < 300; p++) begin
      set_in = 1'b1;
      clr_in = 1'b1;
      repeat (12) @(negedge clk);
      set_in = 1'b0;
      clr_in = 1'b0;
      repeat (8) @(negedge clk);
    end
    check("cnt.model_saturated", 32'(m0.ccnt), 32'd255);
    check("cnt.prio1", 32'(cc0), 32'd255);
    check("cnt.prio0", 32'(cc1), 32'd255);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
